// File: rtl/mips_pkg.sv
// Shared decode constants for the register file / scoreboard slice.
// Optional write-back bypass is enabled with the REGFILE_BYPASS_EN macro.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    RD_RT   = 2'd0,
    RD_RD   = 2'd1,
    RD_LINK = 2'd2,
    RD_NONE = 2'd3
  } reg_dst_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits and read-after-write hazard detection.
// With REGFILE_BYPASS_EN, a register being written back this cycle is not treated as busy.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  input  logic              i_issue_valid,
  input  logic              i_issue_reg_write,
  input  logic [ADDR_W-1:0] i_dest_addr,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  output logic              o_hazard,
  output logic              o_issue_accept
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_d;
  logic             w_rs_busy;
  logic             w_rt_busy;
  logic             w_wb_valid;

  assign w_wb_valid = i_wr_en && (i_wr_addr != '0);

`ifdef REGFILE_BYPASS_EN
  assign w_rs_busy = r_busy[i_rs_addr] && !(w_wb_valid && (i_wr_addr == i_rs_addr));
  assign w_rt_busy = r_busy[i_rt_addr] && !(w_wb_valid && (i_wr_addr == i_rt_addr));
`else
  assign w_rs_busy = r_busy[i_rs_addr];
  assign w_rt_busy = r_busy[i_rt_addr];
`endif

  // Bit 0 is held at zero in the state, so address 0 never reports busy.
  assign o_hazard       = i_issue_valid && (w_rs_busy || w_rt_busy);
  assign o_issue_accept = i_issue_valid && !o_hazard;

  // Clear first, then set: a new producer issuing this cycle wins over the old write-back.
  always_comb begin
    w_busy_d = r_busy;
    if (w_wb_valid) begin
      w_busy_d[i_wr_addr] = 1'b0;
    end
    if (o_issue_accept && i_issue_reg_write && (i_dest_addr != '0)) begin
      w_busy_d[i_dest_addr] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with destination select and busy scoreboard for issue stalls.
// Define REGFILE_BYPASS_EN to forward write-back data to reads in the same cycle.
module regfile_sb
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned LINK_REG = 31
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [1:0]        i_reg_dst,
  input  logic              i_issue_valid,
  input  logic              i_issue_reg_write,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic [DATA_W-1:0] o_rd_data2,
  output logic [ADDR_W-1:0] o_dest_addr,
  output logic              o_hazard,
  output logic              o_issue_accept
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wb_valid;
  logic              w_byp1;
  logic              w_byp2;

  assign w_wb_valid = i_wr_en && (i_wr_addr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wb_valid) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Reset gating keeps the read ports at zero while rst_n is low.
  assign w_byp1 = i_rst_n && w_wb_valid && (i_wr_addr == i_rs_addr);
  assign w_byp2 = i_rst_n && w_wb_valid && (i_wr_addr == i_rt_addr);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign o_rd_data1 = (i_rs_addr == '0) ? '0 : (w_byp1 ? i_wr_data : r_mem[i_rs_addr]);
  assign o_rd_data2 = (i_rt_addr == '0) ? '0 : (w_byp2 ? i_wr_data : r_mem[i_rt_addr]);

  always_comb begin
    o_dest_addr = '0;
    unique case (reg_dst_e'(i_reg_dst))
      RD_RT:   o_dest_addr = i_rt_addr;
      RD_RD:   o_dest_addr = i_rd_addr;
      RD_LINK: o_dest_addr = ADDR_W'(LINK_REG);
      RD_NONE: o_dest_addr = '0;
    endcase
  end

  regfile_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_rs_addr        (i_rs_addr),
    .i_rt_addr        (i_rt_addr),
    .i_issue_valid    (i_issue_valid),
    .i_issue_reg_write(i_issue_reg_write),
    .i_dest_addr      (o_dest_addr),
    .i_wr_en          (i_wr_en),
    .i_wr_addr        (i_wr_addr),
    .o_hazard         (o_hazard),
    .o_issue_accept   (o_issue_accept)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed steps plus random traffic against an array model.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, rd_addr, wr_addr;
  logic [1:0]  reg_dst;
  logic        issue_valid, issue_reg_write, wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data1, rd_data2;
  logic [4:0]  dest_addr;
  logic        hazard, issue_accept;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_sb dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_rs_addr        (rs_addr),
    .i_rt_addr        (rt_addr),
    .i_rd_addr        (rd_addr),
    .i_reg_dst        (reg_dst),
    .i_issue_valid    (issue_valid),
    .i_issue_reg_write(issue_reg_write),
    .i_wr_en          (wr_en),
    .i_wr_addr        (wr_addr),
    .i_wr_data        (wr_data),
    .o_rd_data1       (rd_data1),
    .o_rd_data2       (rd_data2),
    .o_dest_addr      (dest_addr),
    .o_hazard         (hazard),
    .o_issue_accept   (issue_accept)
  );

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic bit byp(input logic [4:0] a);
    return BYP && rst_n && wr_en && (wr_addr == a) && (a != 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (byp(a)) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit busy_eff(input logic [4:0] a);
    return (a != 0) && m_busy[a] && !byp(a);
  endfunction

  function automatic logic [4:0] exp_dest();
    case (reg_dst)
      2'd0:    return rt_addr;
      2'd1:    return rd_addr;
      2'd2:    return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  function automatic bit exp_haz();
    return issue_valid && (busy_eff(rs_addr) || busy_eff(rt_addr));
  endfunction

  // What the block must do at a rising edge, given the inputs presented.
  function automatic void model_edge();
    bit         acc;
    logic [4:0] d;
    acc = issue_valid && !exp_haz();
    d   = exp_dest();
    if (wr_en && wr_addr != 0) begin
      m_mem[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (acc && issue_reg_write && d != 0) m_busy[d] = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rd1"},    rd_data1,     exp_rd(rs_addr));
    chk({tag, ".rd2"},    rd_data2,     exp_rd(rt_addr));
    chk({tag, ".dest"},   {27'd0, dest_addr}, {27'd0, exp_dest()});
    chk({tag, ".hazard"}, {31'd0, hazard}, {31'd0, exp_haz()});
    chk({tag, ".accept"}, {31'd0, issue_accept}, {31'd0, issue_valid && !exp_haz()});
  endtask

  // Commit the current inputs at the next rising edge, then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rs_addr = 0; rt_addr = 0; rd_addr = 0; reg_dst = 2'd3;
    issue_valid = 0; issue_reg_write = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    issue_valid = 1'b1;
    #2;
    // Reset: every address reads 0, no hazard, accept follows issue_valid.
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      #1;
      chk($sformatf("reset_rd[%0d]", i), rd_data1, 32'd0);
      chk($sformatf("reset_rd2[%0d]", i), rd_data2, 32'd0);
    end
    chk("reset_hazard", {31'd0, hazard}, 32'd0);
    chk("reset_accept", {31'd0, issue_accept}, 32'd1);

    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;

    // Write to register 0 is discarded.
    wr_en = 1; wr_addr = 0; wr_data = 32'hDEADBEEF;
    tick();
    idle();
    #1;
    chk("r0_read", rd_data1, 32'd0);

    wr_en = 1; wr_addr = 7; wr_data = 32'h12345678;
    tick();
    idle(); rs_addr = 7;
    #1;
    chk("r7_read", rd_data1, 32'h12345678);

    // jal-style issue marks r31 busy.
    reg_dst = 2'd2; issue_valid = 1; issue_reg_write = 1;
    #1;
    chk("link_dest", {27'd0, dest_addr}, 32'd31);
    chk("link_accept", {31'd0, issue_accept}, 32'd1);
    tick();
    idle(); rs_addr = 31; issue_valid = 1; issue_reg_write = 1; reg_dst = 2'd1; rd_addr = 3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("link_hazard", {31'd0, hazard}, 32'd1);
      chk("link_stall", {31'd0, issue_accept}, 32'd0);
      tick();
    end
    wr_en = 1; wr_addr = 31; wr_data = 32'hCAFE0031;
    #1;
    chk("link_wb_hazard", {31'd0, hazard}, BYP ? 32'd0 : 32'd1);
    chk_all("link_wb");
    tick();
    wr_en = 0;
    #1;
    chk("link_after_hazard", {31'd0, hazard}, 32'd0);
    chk("link_after_rd1", rd_data1, 32'hCAFE0031);
    chk_all("link_after");
    tick();

    // r5 busy, then same-cycle write-back to 5 and a new accepted producer of 5.
    idle(); issue_valid = 1; issue_reg_write = 1; reg_dst = 2'd1; rd_addr = 5;
    tick();
    idle(); issue_valid = 1; issue_reg_write = 1; reg_dst = 2'd1; rd_addr = 5;
    wr_en = 1; wr_addr = 5; wr_data = 32'h00000555;
    #1;
    chk("same_accept", {31'd0, issue_accept}, 32'd1);
    tick();
    idle(); rs_addr = 5; issue_valid = 1;
    #1;
    chk("same_still_busy", {31'd0, hazard}, 32'd1);
    chk("same_data", rd_data1, 32'h00000555);
    wr_en = 1; wr_addr = 5; wr_data = 32'h0;
    tick();
    idle();

    // r9 busy, write-back while rt=9 issues.
    issue_valid = 1; issue_reg_write = 1; reg_dst = 2'd1; rd_addr = 9;
    tick();
    idle(); rt_addr = 9; issue_valid = 1; issue_reg_write = 1; reg_dst = 2'd1; rd_addr = 10;
    wr_en = 1; wr_addr = 9; wr_data = 32'hA5A5A5A5;
    #1;
    chk("byp_hazard", {31'd0, hazard}, BYP ? 32'd0 : 32'd1);
    chk("byp_rd2", rd_data2, BYP ? 32'hA5A5A5A5 : 32'd0);
    tick();
    wr_en = 0;
    #1;
    chk("byp_next_rd2", rd_data2, 32'hA5A5A5A5);
    chk_all("byp_next");
    tick();

    // Random traffic on a narrow address range so hazards and collisions are frequent.
    for (int n = 0; n < 300; n++) begin
      rs_addr = 5'($urandom_range(0, 7));
      rt_addr = 5'($urandom_range(0, 7));
      rd_addr = 5'($urandom_range(0, 7));
      reg_dst = 2'($urandom_range(0, 3));
      issue_valid = 1'($urandom_range(0, 1));
      issue_reg_write = 1'($urandom_range(0, 1));
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 7));
      wr_data = $urandom;
      if (n % 50 == 49) begin
        rs_addr = 31; rt_addr = 30; reg_dst = 2'd2;
      end
      #1;
      chk_all($sformatf("rand[%0d]", n));
      tick();
    end

    // Set some busy bits and data, then reset asynchronously mid-cycle.
    idle(); issue_valid = 1; issue_reg_write = 1; reg_dst = 2'd1; rd_addr = 12;
    wr_en = 1; wr_addr = 12; wr_data = 32'h0BADF00D;
    tick();
    idle(); rs_addr = 12; issue_valid = 1;
    #1;
    chk("pre_reset_hazard", {31'd0, hazard}, 32'd1);
    chk("pre_reset_rd1", rd_data1, 32'h0BADF00D);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_hazard", {31'd0, hazard}, 32'd0);
    chk("async_accept", {31'd0, issue_accept}, 32'd1);
    chk("async_rd1", rd_data1, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(i);
      #1;
      chk($sformatf("async_rd[%0d]", i), rd_data1, 32'd0);
      chk($sformatf("async_hz[%0d]", i), {31'd0, hazard}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(); rs_addr = 12; issue_valid = 1;
    #1;
    chk_all("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle register file and destination mux.
- Combines the register file, a 4-way destination select (rt / rd / link / none) and a per-register busy scoreboard, so a multi-cycle or pipelined core can detect read-after-write hazards.
- Sits between decode (rs/rt/rd, reg_dst) and write-back; its hazard output drives the issue stall.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- LINK_REG, 31, destination index used when reg_dst selects link (jal).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs_addr  in  ADDR_W  read port 1 address.
- rt_addr  in  ADDR_W  read port 2 address.
- rd_addr  in  ADDR_W  R-type destination field.
- reg_dst  in  2  destination select: 0=rt, 1=rd, 2=LINK_REG, 3=none.
- issue_valid  in  1  instruction presented for issue this cycle.
- issue_reg_write  in  1  the issuing instruction writes a register.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  write-back address.
- wr_data  in  DATA_W  write-back data.
- rd_data1  out  DATA_W  contents of rs_addr.
- rd_data2  out  DATA_W  contents of rt_addr.
- dest_addr  out  ADDR_W  selected destination; carried down the pipe by the core.
- hazard  out  1  the issuing instruction reads a busy register.
- issue_accept  out  1  issue_valid & ~hazard.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers clear to 0; all busy bits clear.
  - Outputs: rd_data* = 0, hazard = 0, issue_accept = issue_valid.
- Reads are combinational (zero latency). Register 0 always reads 0 and is never busy.
- Writes:
  - When wr_en = 1 and wr_addr != 0, mem[wr_addr] <= wr_data at the rising edge.
  - Writes to register 0 are discarded.
- dest_addr is combinational: rt_addr, rd_addr, LINK_REG or 0, per reg_dst. reg_dst = 3 yields 0 and means no scoreboard set.
- hazard = issue_valid & (busy[rs_addr] | busy[rt_addr]).
  - Only busy bits of nonzero addresses count.
  - Both read ports are always checked; there is no per-instruction read mask.
- Scoreboard update at each rising edge:
  - Set: when issue_accept & issue_reg_write & dest_addr != 0, set busy[dest_addr].
  - Clear: when wr_en & wr_addr != 0, clear busy[wr_addr].
  - Set and clear of the same register in the same cycle: set wins, because the new producer has issued.
- An issue that is not accepted (hazard = 1) leaves the busy bits and the registers unchanged except for the write-back. The core holds its inputs steady and retries.
- Write-back to a register that is not busy is legal: data is written and the busy bit stays 0.
- rst_n asserted mid-operation: all state clears immediately and in-flight busy bits are lost. The core must flush its pipe on reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - A read whose address equals wr_addr while wr_en = 1 (address nonzero) returns wr_data combinationally.
  - That register's busy bit is masked out of hazard in the same cycle, saving one stall cycle.
- Undefined:
  - Reads return stored contents only.
  - hazard stays asserted until the cycle after the write-back edge.

Decomposition:
- Package mips_pkg:
  - reg_dst encodings RD_RT=0, RD_RD=1, RD_LINK=2, RD_NONE=3.
  - default DATA_W / ADDR_W constants.
- Sub-module regfile_scoreboard (busy-bit vector, set/clear priority, hazard generation), instantiated once.
- Storage and the destination mux stay in the top module.

Test Plan:
- Reset then read all 32 addresses -> every rd_data = 0, hazard = 0.
- Write 0xDEADBEEF to reg 0, then read rs = 0 -> 0. Write 0x12345678 to reg 7, read next cycle -> 0x12345678.
- reg_dst = 2 with issue_valid and issue_reg_write -> dest_addr = 31 and busy[31] set. Next issue with rs = 31 -> hazard = 1 and issue_accept = 0, held until wr_en to 31.
- Same-cycle write-back to 5 and accepted issue writing 5 -> busy[5] remains 1.
- With REGFILE_BYPASS_EN: busy reg 9, wr_en to 9 with 0xA5A5A5A5 while rt = 9 issues -> hazard = 0 and rd_data2 = 0xA5A5A5A5 in the same cycle. Without the macro -> hazard = 1 that cycle and 0 the next.
- Drop rst_n mid-stream with busy bits set -> all busy bits and registers read 0 immediately, before any clock edge.
